// File: rtl/oh_fifo_wr_packer.sv
// Write-side packer: gathers RATIO narrow beats into one wide word carrying a
// beat count and a last flag, and writes it to the async FIFO in the wr_clk
// domain without ever writing while the FIFO reports full.
module oh_fifo_wr_packer #(
   parameter int IW    = 32,
   parameter int RATIO = 4,
   parameter int CW    = $clog2(RATIO) + 1,
   parameter int DW    = IW * RATIO + CW + 1
) (
   input  logic          wr_clk,
   input  logic          wr_nreset,
   input  logic          in_valid,
   input  logic [IW-1:0] in_data,
   input  logic          in_last,
   output logic          in_ready,
   input  logic          flush,
   input  logic          fifo_full,
   output logic          fifo_wr_en,
   output logic [DW-1:0] fifo_din,
   output logic          busy,
   output logic [15:0]   words_written
);

   localparam int IdxW = $clog2(RATIO);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(RATIO - 1);

   logic [IdxW-1:0]     idx_q, idx_d;
   logic [IW*RATIO-1:0] acc_q, acc_d;
   logic                pend_q, pend_d;
   logic [DW-1:0]       outReg_q, outReg_d;
   logic                flushPend_q, flushPend_d;
   logic [15:0]         wordsWritten_q, wordsWritten_d;

   logic                drain;
   logic                slotAvail;
   logic                accept;
   logic                idxNonZero;
   logic                closeBeat;
   logic                closeFlush;
   logic                closeWord;
   logic                lastBit;
   logic [CW-1:0]       countNext;
   logic [IW*RATIO-1:0] lanesNext;

   // Handshake, drain and word-close decisions; in_ready never looks at in_valid
   always_comb begin
      drain      = pend_q & ~fifo_full;
      slotAvail  = ~pend_q | ~fifo_full;
      in_ready   = wr_nreset & slotAvail;
      accept     = in_valid & in_ready;
      idxNonZero = (idx_q != '0);
      closeBeat  = accept & ((idx_q == LastIdx) | in_last | flush | flushPend_q);
      closeFlush = ~accept & (flush | flushPend_q) & idxNonZero & slotAvail;
      closeWord  = closeBeat | closeFlush;
      lastBit    = accept & in_last;
      countNext  = CW'(idx_q) + CW'(accept);
   end

   // Accumulator contents including the beat being accepted this cycle
   always_comb begin
      lanesNext = acc_q;
      if (accept) begin
         lanesNext[int'(idx_q)*IW +: IW] = in_data;
      end
   end

   // Next-state selection; a close may coincide with a drain and simply replaces the word
   always_comb begin
      idx_d          = idx_q;
      acc_d          = acc_q;
      pend_d         = pend_q & ~drain;
      outReg_d       = outReg_q;
      flushPend_d    = flushPend_q | (flush & (idxNonZero | accept));
      wordsWritten_d = wordsWritten_q + 16'(drain);
      if (closeWord) begin
         idx_d       = '0;
         acc_d       = '0;
         pend_d      = 1'b1;
         outReg_d    = {lastBit, countNext, lanesNext};
         flushPend_d = 1'b0;
      end else if (accept) begin
         idx_d = idx_q + 1'b1;
         acc_d = lanesNext;
      end
   end

   // State registers; reset discards any partial word
   always_ff @(posedge wr_clk or negedge wr_nreset) begin
      if (!wr_nreset) begin
         idx_q          <= '0;
         acc_q          <= '0;
         pend_q         <= 1'b0;
         outReg_q       <= '0;
         flushPend_q    <= 1'b0;
         wordsWritten_q <= '0;
      end else begin
         idx_q          <= idx_d;
         acc_q          <= acc_d;
         pend_q         <= pend_d;
         outReg_q       <= outReg_d;
         flushPend_q    <= flushPend_d;
         wordsWritten_q <= wordsWritten_d;
      end
   end

   // Output drive straight from the holding register
   always_comb begin
      fifo_wr_en    = drain;
      fifo_din      = outReg_q;
      busy          = pend_q | idxNonZero;
      words_written = wordsWritten_q;
   end

endmodule
